// File: rtl/alu_muldiv_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// alu_muldiv_seq : multi-cycle execute unit, base ALU ops plus iterative
//                  RV32M multiply / divide / remainder (1 bit per cycle)
// Revision 1.0
// ============================================================================
module alu_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);
  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int CNT_W   = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             neg_q, neg_d, nega_q, nega_d, div0_q, div0_d;

  logic               fire;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   alu_res;
  logic               a_signed, b_signed, sa, sb;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic               div_ok;
  logic [WIDTH-1:0]   step_hi, step_lo, quo_fix, rem_fix, md_res;
  logic [2*WIDTH-1:0] prod_fix;

  assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign fire      = in_valid & in_ready & ~flush;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;
  assign shamt     = b[SHAMT_W-1:0];

  always_comb begin
    case (op[2:0])
      3'd0:    alu_res = a + b;
      3'd1:    alu_res = a - b;
      3'd2:    alu_res = a & b;
      3'd3:    alu_res = a | b;
      3'd4:    alu_res = a ^ b;
      3'd5:    alu_res = a << shamt;
      3'd6:    alu_res = a >> shamt;
      default: alu_res = $unsigned($signed(a) >>> shamt);
    endcase
  end

  // Signed operands: MULH, MULHSU, DIV, REM for a; MULH, DIV, REM for b.
  always_comb begin
    a_signed = op[3] & (op[2] ? ~op[0] : (op[1] ^ op[0]));
    b_signed = op[3] & (op[2] ? ~op[0] : (op[1:0] == 2'b01));
    sa       = a_signed & a[WIDTH-1];
    sb       = b_signed & b[WIDTH-1];
    mag_a    = sa ? -a : a;
    mag_b    = sb ? -b : b;
  end

  // One iteration on {hi,lo}: shift-add multiply (right) or restoring divide (left).
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_ok    = ~div_diff[WIDTH];
    if (op_q[2]) begin
      step_hi = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], div_ok};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
    prod_fix = neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};
    // A zero divisor already yields an all-ones quotient; it must not be negated.
    quo_fix  = (neg_q & ~div0_q) ? -step_lo : step_lo;
    rem_fix  = nega_q ? -step_hi : step_hi;
    if (op_q[2])
      md_res = op_q[1] ? rem_fix : quo_fix;
    else
      md_res = (op_q[1:0] == 2'b00) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    neg_d    = neg_q;
    nega_d   = nega_q;
    div0_d   = div0_q;
    result_d = result_q;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (fire) begin
      op_d  = op[2:0];
      cnt_d = '0;
      if (op[3]) begin
        state_d = CALC;
        hi_d    = '0;
        lo_d    = op[2] ? mag_a : mag_b;
        opnd_d  = op[2] ? mag_b : mag_a;
        neg_d   = sa ^ sb;
        nega_d  = sa;
        div0_d  = (b == '0);
      end else begin
        state_d  = DONE;
        result_d = alu_res;
      end
    end else begin
      case (state_q)
        CALC: begin
          hi_d  = step_hi;
          lo_d  = step_lo;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d  = DONE;
            result_d = md_res;
            cnt_d    = '0;
          end
        end
        DONE: begin
          if (out_ready)
            state_d = IDLE;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      neg_q    <= 1'b0;
      nega_q   <= 1'b0;
      div0_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      neg_q    <= neg_d;
      nega_q   <= nega_d;
      div0_q   <= div0_d;
      result_q <= result_d;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_alu_muldiv_seq : scoreboard bench for alu_muldiv_seq at WIDTH=32 and 8
// Revision 1.0
// ============================================================================
module tb_alu_muldiv_seq;
  logic        clk = 1'b0;
  logic        rst_n, flush;
  logic        out_ready = 1'b1;
  logic        in_valid, in_ready, out_valid, busy;
  logic [3:0]  op;
  logic [31:0] a, b, result;
  logic        iv8, ir8, ov8, busy8;
  logic [3:0]  op8;
  logic [7:0]  a8, b8, res8;

  always #5 clk = ~clk;

  alu_muldiv_seq #(.WIDTH(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy));

  alu_muldiv_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(iv8), .in_ready(ir8),
    .op(op8), .a(a8), .b(b8), .out_valid(ov8), .out_ready(out_ready),
    .result(res8), .busy(busy8));

  typedef struct packed {
    logic [31:0] ev;
    logic [31:0] lat;
    logic [63:0] acc;
  } exp_t;

  exp_t   q32[$];
  exp_t   q8[$];
  int     errors = 0;
  int     checks = 0;
  longint cyc = 0;
  bit     rnd_rdy = 1'b0;
  bit     fixed_rdy = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    out_ready = rnd_rdy ? ($urandom_range(3) != 0) : fixed_rdy;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference behaviour written directly from the arithmetic rules.
  function automatic logic [31:0] model(input int w, input logic [3:0] fop,
                                        input logic [31:0] fa, input logic [31:0] fb);
    longint unsigned m, ua, ub, r;
    longint sa, sb;
    int sh;
    m  = (64'd1 << w) - 64'd1;
    ua = {32'd0, fa} & m;
    ub = {32'd0, fb} & m;
    sa = ((ua >> (w - 1)) & 64'd1) != 0 ? longint'(ua) - (longint'(1) << w) : longint'(ua);
    sb = ((ub >> (w - 1)) & 64'd1) != 0 ? longint'(ub) - (longint'(1) << w) : longint'(ub);
    sh = int'(ub % longint'(w));
    r  = 0;
    case (fop)
      4'd0:  r = ua + ub;
      4'd1:  r = ua - ub;
      4'd2:  r = ua & ub;
      4'd3:  r = ua | ub;
      4'd4:  r = ua ^ ub;
      4'd5:  r = ua << sh;
      4'd6:  r = ua >> sh;
      4'd7:  r = sa >>> sh;
      4'd8:  r = ua * ub;
      4'd9:  r = (sa * sb) >>> w;
      4'd10: r = (sa * longint'(ub)) >>> w;
      4'd11: r = (ua * ub) >> w;
      4'd12: if (ub == 0) r = m; else r = sa / sb;
      4'd13: if (ub == 0) r = m; else r = ua / ub;
      4'd14: if (ub == 0) r = ua; else r = sa % sb;
      default: if (ub == 0) r = ua; else r = ua % ub;
    endcase
    r = r & m;
    return r[31:0];
  endfunction

  function automatic logic [31:0] pick(input int w);
    logic [31:0] mk;
    mk = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    case ($urandom_range(7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return mk;
      3:       return 32'd1 << (w - 1);
      4:       return mk >> 1;
      default: return $urandom & mk;
    endcase
  endfunction

  // Drives one request, waits for the handshake edge and logs the expectation.
  task automatic issue(input bit is8, input logic [3:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] ev, input bit push,
                       output int waited);
    bit acc;
    acc = 1'b0;
    if (is8) begin iv8 = 1'b1; op8 = o; a8 = x[7:0]; b8 = y[7:0]; end
    else     begin in_valid = 1'b1; op = o; a = x; b = y; end
    for (waited = 0; waited < 300; waited++) begin
      @(posedge clk);
      if (is8 ? (iv8 & ir8 & ~flush) : (in_valid & in_ready & ~flush)) begin
        acc = 1'b1;
        break;
      end
    end
    if (!acc) chk("accept_timeout", 64'd0, 64'd1);
    else if (push) begin
      if (is8) q8.push_back('{ev, o[3] ? 32'd9 : 32'd1, cyc});
      else     q32.push_back('{ev, o[3] ? 32'd33 : 32'd1, cyc});
    end
    #1;
    if (is8) iv8 = 1'b0; else in_valid = 1'b0;
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 300; i++) begin
      if (q32.size() == 0 && q8.size() == 0 && !busy && !busy8) break;
      @(posedge clk);
    end
    #1;
    if (i == 300) chk("drain_timeout", 64'd0, 64'd1);
  endtask

  bit          seen32 = 1'b0, seen8 = 1'b0;
  logic [31:0] last32;
  logic [7:0]  last8;

  always @(negedge clk) begin
    if (rst_n) begin
      if (!out_valid) seen32 = 1'b0;
      else begin
        if (!seen32) begin
          if (q32.size() == 0) begin
            errors++; checks++;
            $display("FAIL out32_unexpected: got result %0h with no request pending", result);
          end else begin
            exp_t e;
            e = q32.pop_front();
            chk("result32", {32'd0, result}, {32'd0, e.ev});
            chk("latency32", cyc - e.acc, {32'd0, e.lat});
          end
          seen32 = 1'b1;
          last32 = result;
        end else chk("hold32", {32'd0, result}, {32'd0, last32});
        if (out_ready) seen32 = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (!ov8) seen8 = 1'b0;
      else begin
        if (!seen8) begin
          if (q8.size() == 0) begin
            errors++; checks++;
            $display("FAIL out8_unexpected: got result %0h with no request pending", res8);
          end else begin
            exp_t e;
            e = q8.pop_front();
            chk("result8", {56'd0, res8}, {32'd0, e.ev});
            chk("latency8", cyc - e.acc, {32'd0, e.lat});
          end
          seen8 = 1'b1;
          last8 = res8;
        end else chk("hold8", {56'd0, res8}, {56'd0, last8});
        if (out_ready) seen8 = 1'b0;
      end
    end
  end

  typedef struct packed {
    logic [3:0]  o;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] ev;
  } dir_t;

  dir_t dirs[$] = '{
    '{4'd0,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000},
    '{4'd7,  32'h8000_0000, 32'h0000_0024, 32'hF800_0000},
    '{4'd1,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF},
    '{4'd5,  32'h0000_0001, 32'h0000_003F, 32'h8000_0000},
    '{4'd6,  32'h8000_0000, 32'h0000_0021, 32'h4000_0000},
    '{4'd2,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234},
    '{4'd3,  32'hF000_0000, 32'h0000_000F, 32'hF000_000F},
    '{4'd4,  32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00},
    '{4'd8,  32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE},
    '{4'd9,  32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF},
    '{4'd11, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001},
    '{4'd10, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF},
    '{4'd12, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD},
    '{4'd14, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF},
    '{4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
    '{4'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000},
    '{4'd12, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF},
    '{4'd13, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF},
    '{4'd14, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005},
    '{4'd15, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005}
  };

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int w;
    bit seen;
    rst_n = 1'b0; flush = 1'b0;
    in_valid = 1'b0; op = '0; a = '0; b = '0;
    iv8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_result", {32'd0, result}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (dirs[i]) issue(1'b0, dirs[i].o, dirs[i].x, dirs[i].y, dirs[i].ev, 1'b1, w);
    drain();

    // Stall the consumer, then release it together with a new request.
    fixed_rdy = 1'b0;
    issue(1'b0, 4'd0, 32'd3, 32'd4, 32'd7, 1'b1, w);
    repeat (10) begin
      @(negedge clk);
      chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
    end
    @(posedge clk); #1;
    fixed_rdy = 1'b1;
    issue(1'b0, 4'd8, 32'd7, 32'd6, 32'd42, 1'b1, w);
    chk("b2b_accept_wait", w, 64'd0);
    drain();

    // Flush on the 10th CALC cycle of a DIVU.
    issue(1'b0, 4'd13, 32'd100, 32'd7, 32'd0, 1'b0, w);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", {63'd0, busy}, 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("flush_no_valid", {63'd0, seen}, 64'd0);

    // Flush beats a same-cycle handshake in IDLE.
    @(posedge clk); #1;
    in_valid = 1'b1; op = 4'd0; a = 32'd1; b = 32'd2; flush = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_idle_busy", {63'd0, busy}, 64'd0);

    // Flush beats out_ready plus a new handshake in DONE.
    fixed_rdy = 1'b0;
    issue(1'b0, 4'd0, 32'd1, 32'd1, 32'd2, 1'b1, w);
    @(posedge clk); #1;
    fixed_rdy = 1'b1; flush = 1'b1;
    in_valid = 1'b1; op = 4'd0; a = 32'd5; b = 32'd5;
    @(posedge clk); #1 in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_done_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_done_busy", {63'd0, busy}, 64'd0);

    // Asynchronous reset in the middle of CALC.
    issue(1'b0, 4'd8, 32'd123, 32'd456, 32'd0, 1'b0, w);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    rnd_rdy = 1'b1;
    for (int i = 0; i < 600; i++) begin
      logic [3:0] ro;
      logic [31:0] rx, ry;
      ro = 4'($urandom_range(15));
      rx = pick(32);
      ry = pick(32);
      issue(1'b0, ro, rx, ry, model(32, ro, rx, ry), 1'b1, w);
      repeat ($urandom_range(2)) @(posedge clk);
      #0;
    end
    drain();
    for (int i = 0; i < 1500; i++) begin
      logic [3:0] ro;
      logic [31:0] rx, ry;
      ro = 4'($urandom_range(15));
      rx = pick(8);
      ry = pick(8);
      issue(1'b1, ro, rx, ry, model(8, ro, rx, ry), 1'b1, w);
      repeat ($urandom_range(2)) @(posedge clk);
      #0;
    end
    drain();
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
